// File: rtl/bcd_countdown_timer.sv
// mm:ss BCD countdown timer. Seconds units count mod 10, seconds tens mod 6,
// and N_MIN_DIGITS minute digits mod 10. A run/pause/stop FSM gates the
// external 1 Hz tick. Loads are clamped per digit. Expiry either parks in
// DONE with a one-cycle done pulse or, with AUTO_RELOAD, reloads and keeps
// running.
module bcd_countdown_timer #(
  parameter int N_MIN_DIGITS = 2,
  parameter bit AUTO_RELOAD  = 1'b0,
  localparam int D = N_MIN_DIGITS + 2,
  localparam int W = 4 * D
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         start,
  input  logic         pause,
  input  logic         stop,
  input  logic         tick,
  output logic [W-1:0] count,
  output logic         running,
  output logic         paused,
  output logic         zero,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic [W-1:0]   saved_q, saved_d;
  logic           done_q, done_d;
  logic           running_q, paused_q;

  logic [W-1:0]   clamped;   // data with each digit forced into its legal range
  logic [W-1:0]   dec;       // count_q minus one second
  logic [D-1:0]   borrow;    // borrow into each digit, LSD first

  assign borrow[0] = 1'b1;

  // Per-digit clamp and borrow-chain decrement.
  for (genvar gi = 0; gi < D; gi++) begin : g_digit
    localparam logic [3:0] DMAX = (gi == 1) ? 4'd5 : 4'd9;
    logic [3:0] din;
    logic [3:0] dig;

    assign din = data[4*gi +: 4];
    assign dig = count_q[4*gi +: 4];

    // Seconds tens clamps straight to 5: anything above 9 is also above 5.
    assign clamped[4*gi +: 4] = (din > DMAX) ? DMAX : din;

    assign dec[4*gi +: 4] = borrow[gi] ? ((dig == 4'd0) ? DMAX : dig - 4'd1) : dig;

    if (gi < D - 1) begin : g_borrow
      assign borrow[gi+1] = borrow[gi] && (dig == 4'd0);
    end
  end

  // Next-state logic: stop overrides everything, then load > start > pause > tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    saved_d = saved_q;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (load) begin
            count_d = clamped;
            saved_d = clamped;
          end else if (start && (count_q != '0)) begin
            state_d = S_RUN;
          end
        end

        S_RUN: begin
          // load is deliberately ignored while counting.
          if (pause) begin
            state_d = S_PAUSE;
          end else if (tick && (count_q != '0)) begin
            done_d = (dec == '0);
            if (dec != '0) begin
              count_d = dec;
            end else if (AUTO_RELOAD && (saved_q != '0)) begin
              count_d = saved_q;
            end else begin
              count_d = '0;
              state_d = S_DONE;
            end
          end
        end

        S_PAUSE: begin
          if (load) begin
            count_d = clamped;
            saved_d = clamped;
            state_d = S_IDLE;
          end else if (start) begin
            state_d = S_RUN;
          end
        end

        S_DONE: begin
          if (load) begin
            count_d = clamped;
            saved_d = clamped;
            state_d = S_IDLE;
          end else if (start && (saved_q != '0)) begin
            count_d = saved_q;
            state_d = S_RUN;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, count and registered status outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      saved_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      saved_q   <= saved_d;
      done_q    <= done_d;
      running_q <= (state_d == S_RUN);
      paused_q  <= (state_d == S_PAUSE);
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign paused  = paused_q;
  assign done    = done_q;
  assign zero    = (count_q == '0);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: one plain instance and one
// AUTO_RELOAD instance share stimulus; the reload instance is held in clear
// until its own scenario runs.
module tb_bcd_countdown_timer;

  localparam logic [5:0] CLR = 6'b100000;
  localparam logic [5:0] STP = 6'b010000;
  localparam logic [5:0] LD  = 6'b001000;
  localparam logic [5:0] STA = 6'b000100;
  localparam logic [5:0] PAU = 6'b000010;
  localparam logic [5:0] TCK = 6'b000001;
  localparam logic [5:0] NON = 6'b000000;

  logic        clk = 1'b0;
  logic        clear = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0, tick = 1'b0;
  logic [15:0] data = 16'h0;
  logic        hold_ar = 1'b1;
  logic        clear_ar;

  logic [15:0] count_m, count_a;
  logic        running_m, paused_m, zero_m, done_m;
  logic        running_a, paused_a, zero_a, done_a;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    bit          ar;
    logic [15:0] cnt;
    logic        run;
    logic        pau;
    logic        dn;
  } exp_t;

  exp_t sb_q[$];

  assign clear_ar = clear | hold_ar;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.N_MIN_DIGITS(2), .AUTO_RELOAD(1'b0)) u_dut (
    .clk(clk), .clear(clear), .load(load), .data(data), .start(start),
    .pause(pause), .stop(stop), .tick(tick), .count(count_m),
    .running(running_m), .paused(paused_m), .zero(zero_m), .done(done_m)
  );

  bcd_countdown_timer #(.N_MIN_DIGITS(2), .AUTO_RELOAD(1'b1)) u_dut_ar (
    .clk(clk), .clear(clear_ar), .load(load), .data(data), .start(start),
    .pause(pause), .stop(stop), .tick(tick), .count(count_a),
    .running(running_a), .paused(paused_a), .zero(zero_a), .done(done_a)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of controls, queue the expected result, compare after the edge.
  task automatic step(input string tag, input logic [5:0] ctl, input logic [15:0] d,
                      input bit ar, input logic [15:0] cnt,
                      input logic run, input logic pau, input logic dn);
    exp_t e;
    logic [15:0] o_cnt;
    logic        o_run, o_pau, o_dn, o_zero;
    e.tag = tag; e.ar = ar; e.cnt = cnt; e.run = run; e.pau = pau; e.dn = dn;
    sb_q.push_back(e);
    {clear, stop, load, start, pause, tick} = ctl;
    data = d;
    @(posedge clk);
    #1;
    {clear, stop, load, start, pause, tick} = NON;
    e = sb_q.pop_front();
    o_cnt  = e.ar ? count_a   : count_m;
    o_run  = e.ar ? running_a : running_m;
    o_pau  = e.ar ? paused_a  : paused_m;
    o_dn   = e.ar ? done_a    : done_m;
    o_zero = e.ar ? zero_a    : zero_m;
    check_eq({e.tag, ".count"},   {16'h0, o_cnt}, {16'h0, e.cnt});
    check_eq({e.tag, ".running"}, {31'h0, o_run}, {31'h0, e.run});
    check_eq({e.tag, ".paused"},  {31'h0, o_pau}, {31'h0, e.pau});
    check_eq({e.tag, ".done"},    {31'h0, o_dn},  {31'h0, e.dn});
    check_eq({e.tag, ".zero"},    {31'h0, o_zero}, {31'h0, (e.cnt == 16'h0)});
    $display("[%s] dut=%0d count=%04h run=%0b pau=%0b done=%0b zero=%0b",
             e.tag, e.ar, o_cnt, o_run, o_pau, o_dn, o_zero);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] t1 [5];
    t1 = '{16'h0129, 16'h0128, 16'h0127, 16'h0126, 16'h0125};

    // Reset and simple countdown.
    step("clr",     CLR, 16'h0,    0, 16'h0000, 0, 0, 0);
    step("start0",  STA, 16'h0,    0, 16'h0000, 0, 0, 0);
    step("ld0130",  LD,  16'h0130, 0, 16'h0130, 0, 0, 0);
    step("go0130",  STA, 16'h0,    0, 16'h0130, 1, 0, 0);
    for (int i = 0; i < 5; i++) step($sformatf("tk%0d", i), TCK, 16'h0, 0, t1[i], 1, 0, 0);
    step("stop1",   STP, 16'h0,    0, 16'h0000, 0, 0, 0);

    // Borrows across seconds tens and minute digits.
    step("ld0100",  LD,  16'h0100, 0, 16'h0100, 0, 0, 0);
    step("go0100",  STA, 16'h0,    0, 16'h0100, 1, 0, 0);
    step("tk0059",  TCK, 16'h0,    0, 16'h0059, 1, 0, 0);
    step("stop2",   STP, 16'h0,    0, 16'h0000, 0, 0, 0);
    step("ld1000",  LD,  16'h1000, 0, 16'h1000, 0, 0, 0);
    step("go1000",  STA, 16'h0,    0, 16'h1000, 1, 0, 0);
    step("tk0959",  TCK, 16'h0,    0, 16'h0959, 1, 0, 0);
    step("stop3",   STP, 16'h0,    0, 16'h0000, 0, 0, 0);

    // Expiry into DONE, then restart from DONE.
    step("ld0002",  LD,  16'h0002, 0, 16'h0002, 0, 0, 0);
    step("go0002",  STA, 16'h0,    0, 16'h0002, 1, 0, 0);
    step("tk0001",  TCK, 16'h0,    0, 16'h0001, 1, 0, 0);
    step("tkexp",   TCK, 16'h0,    0, 16'h0000, 0, 0, 1);
    step("tkdone1", TCK, 16'h0,    0, 16'h0000, 0, 0, 0);
    step("tkdone2", TCK, 16'h0,    0, 16'h0000, 0, 0, 0);
    step("restart", STA, 16'h0,    0, 16'h0002, 1, 0, 0);
    step("stop4",   STP, 16'h0,    0, 16'h0000, 0, 0, 0);

    // Pause / resume, pause beats same-cycle tick, load from PAUSED.
    step("ld0005",  LD,  16'h0005, 0, 16'h0005, 0, 0, 0);
    step("go0005",  STA, 16'h0,    0, 16'h0005, 1, 0, 0);
    step("tk0004",  TCK, 16'h0,    0, 16'h0004, 1, 0, 0);
    step("tk0003",  TCK, 16'h0,    0, 16'h0003, 1, 0, 0);
    step("pause",   PAU, 16'h0,    0, 16'h0003, 0, 1, 0);
    for (int i = 0; i < 3; i++) step($sformatf("ptk%0d", i), TCK, 16'h0, 0, 16'h0003, 0, 1, 0);
    step("resume",  STA, 16'h0,    0, 16'h0003, 1, 0, 0);
    step("tk0002",  TCK, 16'h0,    0, 16'h0002, 1, 0, 0);
    step("pau+tk",  PAU | TCK, 16'h0, 0, 16'h0002, 0, 1, 0);
    step("pld0040", LD,  16'h0040, 0, 16'h0040, 0, 0, 0);
    step("stop5",   STP, 16'h0,    0, 16'h0000, 0, 0, 0);

    // Load clamping.
    step("ldAF7C",  LD,  16'hAF7C, 0, 16'h9959, 0, 0, 0);
    step("stop6",   STP, 16'h0,    0, 16'h0000, 0, 0, 0);

    // Auto-reload instance.
    hold_ar = 1'b0;
    step("ar_ld",   LD,  16'h0002, 1, 16'h0002, 0, 0, 0);
    step("ar_go",   STA, 16'h0,    1, 16'h0002, 1, 0, 0);
    step("ar_tk1",  TCK, 16'h0,    1, 16'h0001, 1, 0, 0);
    step("ar_tk2",  TCK, 16'h0,    1, 16'h0002, 1, 0, 1);
    step("ar_tk3",  TCK, 16'h0,    1, 16'h0001, 1, 0, 0);
    step("ar_tk4",  TCK, 16'h0,    1, 16'h0002, 1, 0, 1);
    step("ar_stop", STP, 16'h0,    1, 16'h0000, 0, 0, 0);

    // stop at 00:01 together with tick: no done pulse.
    step("ld0002b", LD,  16'h0002, 0, 16'h0002, 0, 0, 0);
    step("go0002b", STA, 16'h0,    0, 16'h0002, 1, 0, 0);
    step("tk0001b", TCK, 16'h0,    0, 16'h0001, 1, 0, 0);
    step("stop+tk", STP | TCK, 16'h0, 0, 16'h0000, 0, 0, 0);

    // clear mid-run together with tick and load.
    step("ld0010",  LD,  16'h0010, 0, 16'h0010, 0, 0, 0);
    step("go0010",  STA, 16'h0,    0, 16'h0010, 1, 0, 0);
    step("tk0009",  TCK, 16'h0,    0, 16'h0009, 1, 0, 0);
    step("clr+all", CLR | TCK | LD, 16'h0030, 0, 16'h0000, 0, 0, 0);
    step("idle",    NON, 16'h0,    0, 16'h0000, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
